sdram_req_arbiter: RTL and testbench

- Shares the single SDRAM controller command port between N_REQ bus requesters: display scanout (port 0), CPU (port 1), and blitter/DMA (port 2).
- Selects one request, presents it to the controller with a valid/ready handshake, then owns the bus until the burst's data beats complete.
- Sits in doomsoc_core between the requester ports and the SDRAM controller.
- Port 0 can be marked urgent by the display FIFO low-watermark.

---
 rtl/sdram_req_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sdram_req_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_req_arbiter.sv
// Arbitrates N_REQ requesters onto one SDRAM controller command port and holds ownership until the burst's beats finish.
// Optional request aging is enabled with `define SDRAM_REQ_ARBITER_AGING_EN.
module sdram_req_arbiter #(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned W_ADDR   = 25,
  parameter int unsigned W_LEN    = 4,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [N_REQ-1:0]                        req_valid,
  output logic [N_REQ-1:0]                        req_ready,
  input  logic [N_REQ*W_ADDR-1:0]                 req_addr,
  input  logic [N_REQ-1:0]                        req_write,
  input  logic [N_REQ*W_LEN-1:0]                  req_len,
  input  logic                                    urgent,
  output logic                                    cmd_valid,
  input  logic                                    cmd_ready,
  output logic [W_ADDR-1:0]                       cmd_addr,
  output logic                                    cmd_write,
  output logic [W_LEN-1:0]                        cmd_len,
  input  logic                                    beat,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id,
  output logic                                    busy,
  output logic                                    err_beat
);

  localparam int unsigned W_ID = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  if (N_REQ < 2 || N_REQ > 8 || MAX_WAIT < 1) begin : g_bad_cfg
    $error("sdram_req_arbiter: unsupported N_REQ or MAX_WAIT");
  end

  logic [1:0]        state_q, state_d;
  logic [W_LEN-1:0]  cnt_q, cnt_d;
  logic [W_ID-1:0]   rr_last_q, rr_last_d;
  logic [W_ID-1:0]   winner_c, scan_c;
  logic              rr_found_c;
  logic [N_REQ-1:0]  grant_c;
  logic              cmd_valid_d, cmd_write_d, busy_d, err_beat_d;
  logic [W_ADDR-1:0] cmd_addr_d;
  logic [W_LEN-1:0]  cmd_len_d;
  logic [W_ID-1:0]   grant_id_d;

  // No accept pulse may escape while reset is held.
  assign req_ready = rst_n ? grant_c : '0;

`ifdef SDRAM_REQ_ARBITER_AGING_EN
  localparam int unsigned W_WAIT = $clog2(MAX_WAIT) + 1;

  logic [W_WAIT-1:0] wait_q [N_REQ];
  logic [W_WAIT-1:0] wait_d [N_REQ];
  logic [N_REQ-1:0]  aged_c;

  // Saturating per-requester wait counters.
  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      aged_c[i] = (wait_q[i] >= W_WAIT'(MAX_WAIT));
      wait_d[i] = '0;
      if (req_valid[i] && !req_ready[i]) begin
        wait_d[i] = (&wait_q[i]) ? wait_q[i] : wait_q[i] + W_WAIT'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_REQ); i++) wait_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_REQ); i++) wait_q[i] <= wait_d[i];
    end
  end
`endif

  // Winner: aged (optional) > urgent port 0 > round-robin after rr_last.
  always_comb begin
    winner_c   = '0;
    scan_c     = '0;
    rr_found_c = 1'b0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      scan_c = W_ID'((32'(rr_last_q) + 32'(k)) % 32'(N_REQ));
      if (!rr_found_c && req_valid[scan_c]) begin
        rr_found_c = 1'b1;
        winner_c   = scan_c;
      end
    end
    if (urgent && req_valid[0]) winner_c = '0;
`ifdef SDRAM_REQ_ARBITER_AGING_EN
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (aged_c[i] && req_valid[i]) winner_c = W_ID'(i);
    end
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_last_d   = rr_last_q;
    grant_c     = '0;
    cmd_valid_d = cmd_valid;
    cmd_addr_d  = cmd_addr;
    cmd_write_d = cmd_write;
    cmd_len_d   = cmd_len;
    grant_id_d  = grant_id;
    busy_d      = busy;
    err_beat_d  = err_beat;

    case (state_q)
      IDLE: begin
        if (beat) err_beat_d = 1'b1;
        if (|req_valid) begin
          for (int i = 0; i < int'(N_REQ); i++) begin
            if (winner_c == W_ID'(i)) begin
              grant_c[i]  = 1'b1;
              cmd_addr_d  = req_addr[i*W_ADDR +: W_ADDR];
              cmd_write_d = req_write[i];
              cmd_len_d   = req_len[i*W_LEN +: W_LEN];
            end
          end
          grant_id_d  = winner_c;
          rr_last_d   = winner_c;
          cmd_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = CMD;
        end
      end
      CMD: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = DATA;
          // A beat alongside the accept is the burst's first beat.
          if (beat) begin
            if (cmd_len == '0) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              cnt_d = W_LEN'(1);
            end
          end
        end else if (beat) begin
          err_beat_d = 1'b1;
        end
      end
      DATA: begin
        if (beat) begin
          if (cnt_q == cmd_len) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + W_LEN'(1);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_last_q <= W_ID'(N_REQ - 1);
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_write <= 1'b0;
      cmd_len   <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      err_beat  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
      cmd_valid <= cmd_valid_d;
      cmd_addr  <= cmd_addr_d;
      cmd_write <= cmd_write_d;
      cmd_len   <= cmd_len_d;
      grant_id  <= grant_id_d;
      busy      <= busy_d;
      err_beat  <= err_beat_d;
    end
  end

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Bench for sdram_req_arbiter: directed vector table, hand sequences and a randomized run against a transaction-level model.
module tb_sdram_req_arbiter;

  localparam int N_REQ    = 3;
  localparam int W_ADDR   = 25;
  localparam int W_LEN    = 4;
  localparam int MAX_WAIT = 16;
  localparam int W_ID     = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ*W_ADDR-1:0]   req_addr;
  logic [N_REQ-1:0]          req_write;
  logic [N_REQ*W_LEN-1:0]    req_len;
  logic                      urgent;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [W_ADDR-1:0]         cmd_addr;
  logic                      cmd_write;
  logic [W_LEN-1:0]          cmd_len;
  logic                      beat;
  logic [W_ID-1:0]           grant_id;
  logic                      busy;
  logic                      err_beat;

  always #5 clk = ~clk;

  sdram_req_arbiter #(
    .N_REQ(N_REQ), .W_ADDR(W_ADDR), .W_LEN(W_LEN), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_len(req_len), .urgent(urgent),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_len(cmd_len), .beat(beat), .grant_id(grant_id),
    .busy(busy), .err_beat(err_beat)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the port, whether the command is still offered, beats left.
  bit               m_busy, m_cmd, m_err, m_write;
  int               m_left, m_owner, m_rr, m_len;
  logic [W_ADDR-1:0] m_addr;
  int               m_wait [N_REQ];
  logic [N_REQ-1:0] m_rdy;

  task automatic model_reset();
    m_busy = 0; m_cmd = 0; m_err = 0; m_write = 0;
    m_left = 0; m_owner = 0; m_rr = N_REQ - 1; m_len = 0; m_addr = '0;
    for (int i = 0; i < N_REQ; i++) m_wait[i] = 0;
    m_rdy = '0;
  endtask

  // Round-robin as "smallest distance past the last winner".
  function automatic int pick();
    int best = -1;
    int bestd = N_REQ + 1;
`ifdef SDRAM_REQ_ARBITER_AGING_EN
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req_valid[i] && m_wait[i] >= MAX_WAIT) best = i;
    if (best >= 0) return best;
`endif
    if (urgent && req_valid[0]) return 0;
    for (int i = 0; i < N_REQ; i++) begin
      int d;
      d = (i - m_rr - 1 + 2 * N_REQ) % N_REQ;
      if (req_valid[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  function automatic logic [N_REQ-1:0] exp_ready();
    logic [N_REQ-1:0] r;
    r = '0;
    if (!m_busy && (|req_valid)) r = N_REQ'(1) << pick();
    return r;
  endfunction

  task automatic model_advance();
    int w;
    if (!m_busy) begin
      if (beat) m_err = 1;
      if (|req_valid) begin
        w = pick();
        m_busy = 1; m_cmd = 1; m_owner = w; m_rr = w;
        m_addr  = req_addr[w*W_ADDR +: W_ADDR];
        m_write = req_write[w];
        m_len   = int'(req_len[w*W_LEN +: W_LEN]);
        m_left  = m_len + 1;
      end
    end else if (m_cmd) begin
      if (cmd_ready) begin
        m_cmd = 0;
        if (beat) begin
          m_left--;
          if (m_left == 0) m_busy = 0;
        end
      end else if (beat) begin
        m_err = 1;
      end
    end else if (beat) begin
      m_left--;
      if (m_left == 0) m_busy = 0;
    end
`ifdef SDRAM_REQ_ARBITER_AGING_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && !m_rdy[i]) m_wait[i] = (m_wait[i] < MAX_WAIT) ? m_wait[i] + 1 : MAX_WAIT;
      else m_wait[i] = 0;
    end
`endif
  endtask

  task automatic compare_model();
    chk("req_ready", 64'(req_ready), 64'(m_rdy));
    chk("cmd_valid", 64'(cmd_valid), 64'(m_cmd));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("grant_id", 64'(grant_id), 64'(m_owner));
    chk("cmd_addr", 64'(cmd_addr), 64'(m_addr));
    chk("cmd_write", 64'(cmd_write), 64'(m_write));
    chk("cmd_len", 64'(cmd_len), 64'(m_len));
    chk("err_beat", 64'(err_beat), 64'(m_err));
  endtask

  task automatic sample(input bit do_cmp);
    @(negedge clk);
    m_rdy = exp_ready();
    if (do_cmp) compare_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  // Single len-0 transaction offered by the ports in v; checks who is accepted.
  task automatic one_txn(input logic [N_REQ-1:0] v, input bit urg, input logic [N_REQ-1:0] exp_rdy,
                         input string name);
    req_valid = v; urgent = urg; cmd_ready = 1'b1; beat = 1'b0;
    sample(1);
    chk(name, 64'(req_ready), 64'(exp_rdy));
    advance();
    req_valid = '0; urgent = 1'b0; beat = 1'b1;
    sample(1);
    advance();
    beat = 1'b0;
  endtask

  typedef struct {
    logic [N_REQ-1:0] valid;
    logic             urg;
    logic             cr;
    logic             bt;
    logic [N_REQ-1:0] rdy;
    logic             cv;
    logic             bsy;
    logic [W_ID-1:0]  gid;
    logic             err;
  } vec_t;

  vec_t tbl [9];
  int   g2_cycle;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; req_valid = '0; req_addr = '0; req_write = '0; req_len = '0;
    urgent = 1'b0; cmd_ready = 1'b0; beat = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_err_beat", 64'(err_beat), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Round robin 0,1,2,0 with every port always requesting, len 0, one beat per command.
    tbl[0] = '{3'b111, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[1] = '{3'b111, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[2] = '{3'b111, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[3] = '{3'b111, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 2'd1, 1'b0};
    tbl[4] = '{3'b111, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[5] = '{3'b111, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 2'd2, 1'b0};
    tbl[6] = '{3'b111, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 2'd2, 1'b0};
    tbl[7] = '{3'b111, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[8] = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0};
    req_addr = {25'h0000333, 25'h0000222, 25'h0000111};
    for (int r = 0; r < 9; r++) begin
      req_valid = tbl[r].valid; urgent = tbl[r].urg; cmd_ready = tbl[r].cr; beat = tbl[r].bt;
      sample(0);
      chk($sformatf("tbl%0d_req_ready", r), 64'(req_ready), 64'(tbl[r].rdy));
      chk($sformatf("tbl%0d_cmd_valid", r), 64'(cmd_valid), 64'(tbl[r].cv));
      chk($sformatf("tbl%0d_busy", r), 64'(busy), 64'(tbl[r].bsy));
      chk($sformatf("tbl%0d_grant_id", r), 64'(grant_id), 64'(tbl[r].gid));
      chk($sformatf("tbl%0d_err_beat", r), 64'(err_beat), 64'(tbl[r].err));
      advance();
    end

    // Port 1 write burst of 8 beats with a slow command accept.
    req_valid = 3'b010; urgent = 1'b0; cmd_ready = 1'b0; beat = 1'b0;
    req_addr[1*W_ADDR +: W_ADDR] = 25'h1ABCDE; req_write = 3'b010;
    req_len = {4'd0, 4'd7, 4'd0};
    sample(1);
    chk("a_grant", 64'(req_ready), 64'(3'b010));
    advance();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      sample(1);
      chk("a_hold_addr", 64'(cmd_addr), 64'h1ABCDE);
      chk("a_hold_len", 64'(cmd_len), 64'd7);
      chk("a_hold_valid", 64'(cmd_valid), 64'd1);
      advance();
    end
    cmd_ready = 1'b1; beat = 1'b1;
    sample(1);
    advance();
    cmd_ready = 1'b0;
    for (int k = 1; k < 8; k++) begin
      sample(1);
      chk("a_busy_mid", 64'(busy), 64'd1);
      advance();
    end
    beat = 1'b0;
    sample(1);
    chk("a_busy_after", 64'(busy), 64'd0);
    chk("a_grant_id", 64'(grant_id), 64'd1);
    advance();

    // Urgent versus round robin with rr_last on port 0.
    req_len = '0; req_write = '0;
    one_txn(3'b001, 1'b0, 3'b001, "b_setup");
    one_txn(3'b011, 1'b1, 3'b001, "b_urgent");
    one_txn(3'b001, 1'b0, 3'b001, "b_setup2");
    one_txn(3'b011, 1'b0, 3'b010, "b_rr");

    // Urgent port 0 streams continuously while port 2 waits.
    req_valid = 3'b101; urgent = 1'b1; cmd_ready = 1'b1; beat = 1'b0;
    g2_cycle = -1;
    for (int k = 0; k < 60; k++) begin
      sample(1);
      if (req_ready[2] && g2_cycle < 0) g2_cycle = k;
      advance();
      if (m_rdy[2]) req_valid[2] = 1'b0;
      beat = m_busy && m_cmd;
    end
`ifdef SDRAM_REQ_ARBITER_AGING_EN
    chk("e_aged_grant_cycle", 64'(g2_cycle), 64'(16));
`else
    chk("e_port2_starved", 64'(g2_cycle), 64'(-1));
`endif
    req_valid = '0; urgent = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!m_busy) break;
      beat = m_cmd;
      sample(1);
      advance();
    end
    beat = 1'b0;

    // Beat while idle is flagged and sticky; traffic continues.
    beat = 1'b1;
    sample(1);
    advance();
    beat = 1'b0;
    sample(1);
    chk("c_err_set", 64'(err_beat), 64'd1);
    advance();
    one_txn(3'b100, 1'b0, 3'b100, "c_txn");
    sample(1);
    chk("c_err_sticky", 64'(err_beat), 64'd1);
    chk("c_txn_done", 64'(busy), 64'd0);
    advance();

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      sample(1);
      advance();
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && m_rdy[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(2) == 0) begin
          req_valid[i] = 1'b1;
          req_addr[i*W_ADDR +: W_ADDR] = W_ADDR'($urandom);
          req_write[i] = 1'($urandom_range(1));
          req_len[i*W_LEN +: W_LEN] = W_LEN'($urandom_range(3));
        end
      end
      urgent    = ($urandom_range(3) == 0);
      cmd_ready = 1'($urandom_range(1));
      beat      = (m_busy && !m_cmd) ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0);
    end

    req_valid = '0; urgent = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!m_busy) break;
      cmd_ready = 1'b1; beat = 1'b1;
      sample(1);
      advance();
    end
    cmd_ready = 1'b0; beat = 1'b0;

    // Reset in the middle of a data phase (3 of 8 beats done).
    req_len = {4'd7, 4'd7, 4'd7};
    req_valid = 3'b100;
    sample(1);
    advance();
    req_valid = 3'b111; cmd_ready = 1'b1;
    sample(1);
    advance();
    cmd_ready = 1'b0; beat = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample(1);
      advance();
    end
    beat = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("d_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("d_busy", 64'(busy), 64'd0);
    chk("d_req_ready", 64'(req_ready), 64'd0);
    chk("d_grant_id", 64'(grant_id), 64'd0);
    chk("d_err_beat", 64'(err_beat), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    sample(1);
    chk("d_first_grant", 64'(req_ready), 64'(3'b001));
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
